// File: rtl/change_event_arbiter_if.sv
// Event port bundle between the change-event arbiter and its status inputs and consumer.
// The master side is the arbiter; the slave side drives the monitored signals and consumes events.
interface change_event_arbiter_if #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] sig;
    logic [NUM_CH-1:0] ch_en;
    logic              evt_valid;
    logic              evt_ready;
    logic [IDX_W-1:0]  evt_ch;
    logic              evt_rise;
    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] overflow_clr;

    modport master (
        input  sig, ch_en, evt_ready, overflow_clr,
        output evt_valid, evt_ch, evt_rise, overflow
    );

    modport slave (
        output sig, ch_en, evt_ready, overflow_clr,
        input  evt_valid, evt_ch, evt_rise, overflow
    );
endinterface

// File: rtl/change_event_arbiter.sv
// Detects level changes on NUM_CH inputs, holds one pending event per channel and
// serialises them round-robin onto a single valid/ready event port.
module change_event_arbiter #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    change_event_arbiter_if.master bus
);
    typedef enum logic {EMPTY, OFFER} state_t;

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pend_rise;
    logic [NUM_CH-1:0] overflow_q;
    logic [NUM_CH-1:0] chg;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] load_sel;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  evt_ch_reg;
    logic              evt_rise_reg;
    logic [IDX_W-1:0]  arb_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic              found;
    logic              any_req;
    logic              handshake;
    logic              load;

    assign chg       = bus.sig ^ prev;
    // A disabled channel is being dropped on this edge, so it must not win arbitration.
    assign req       = pending & bus.ch_en;
    assign any_req   = |req;
    assign handshake = (state_reg == OFFER) && bus.evt_ready;

    // Back-to-back loads arbitrate from the pointer as it will be after this handshake.
    assign arb_ptr = handshake
                   ? ((evt_ch_reg == IDX_W'(NUM_CH - 1)) ? '0 : evt_ch_reg + IDX_W'(1))
                   : rr_ptr_reg;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[(int'(arb_ptr) + k) % NUM_CH]) begin
                found   = 1'b1;
                win_idx = IDX_W'((int'(arb_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (any_req) begin
                    load       = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (handshake) begin
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign load_sel = load ? (NUM_CH'(1) << win_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            evt_ch_reg   <= '0;
            evt_rise_reg <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr_reg <= arb_ptr;
            end
            if (load) begin
                evt_ch_reg   <= win_idx;
                evt_rise_reg <= pend_rise[win_idx];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic prev_reg;
            logic pending_reg;
            logic rise_reg;
            logic ovf_reg;
            logic ovf_set;

            // A change on a bit being loaded this edge is a fresh event, not a lost one.
            assign ovf_set = bus.ch_en[gi] & chg[gi] & pending_reg & ~load_sel[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                    rise_reg    <= 1'b0;
                    ovf_reg     <= 1'b0;
                end else begin
                    prev_reg <= bus.sig[gi];
                    ovf_reg  <= (ovf_reg & ~bus.overflow_clr[gi]) | ovf_set;
                    if (!bus.ch_en[gi]) begin
                        pending_reg <= 1'b0;
                    end else if (chg[gi]) begin
                        pending_reg <= 1'b1;
                        rise_reg    <= bus.sig[gi];
                    end else if (load_sel[gi]) begin
                        pending_reg <= 1'b0;
                    end
                end
            end

            assign prev[gi]       = prev_reg;
            assign pending[gi]    = pending_reg;
            assign pend_rise[gi]  = rise_reg;
            assign overflow_q[gi] = ovf_reg;
        end
    endgenerate

    assign bus.evt_valid = (state_reg == OFFER);
    assign bus.evt_ch    = evt_ch_reg;
    assign bus.evt_rise  = evt_rise_reg;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_change_event_arbiter.sv
// Directed bench for change_event_arbiter: latency, round-robin order, hold-off,
// overflow handling, pointer wrap and asynchronous reset mid-offer.
module tb_change_event_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    change_event_arbiter_if #(.NUM_CH(8)) bus();

    change_event_arbiter #(.NUM_CH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [2:0] ch, input logic r);
        check({tag, "_valid"}, 32'(bus.evt_valid), 32'(v));
        if (v) begin
            check({tag, "_ch"},   32'(bus.evt_ch),   32'(ch));
            check({tag, "_rise"}, 32'(bus.evt_rise), 32'(r));
        end
        $display("step %s: valid=%0d ch=%0d rise=%0d ovf=%02h", tag,
                 bus.evt_valid, bus.evt_ch, bus.evt_rise, bus.overflow);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sig          = '0;
        bus.ch_en        = 8'hFF;
        bus.evt_ready    = 1'b0;
        bus.overflow_clr = '0;
        tick(2);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_ch",    32'(bus.evt_ch),    32'd0);
        check("rst_rise",  32'(bus.evt_rise),  32'd0);
        check("rst_ovf",   32'(bus.overflow),  32'd0);
        rst = 1'b0;

        // 1: single rising change, two-cycle latency, one-cycle pulse with ready high
        bus.sig = 8'h04; bus.evt_ready = 1'b1;
        tick(1); check_evt("t1_lat1", 1'b0, 3'd0, 1'b0);
        tick(1); check_evt("t1_evt",  1'b1, 3'd2, 1'b1);
        tick(1); check_evt("t1_done", 1'b0, 3'd0, 1'b0);

        rst = 1'b1; bus.sig = '0;
        tick(2);
        rst = 1'b0;

        // 2: simultaneous changes drained round-robin from pointer 0
        bus.sig = 8'h29;
        tick(1); check_evt("t2_lat1", 1'b0, 3'd0, 1'b0);
        tick(1); check_evt("t2_e0",   1'b1, 3'd0, 1'b1);
        tick(1); check_evt("t2_e3",   1'b1, 3'd3, 1'b1);
        tick(1); check_evt("t2_e5",   1'b1, 3'd5, 1'b1);
        tick(1); check_evt("t2_done", 1'b0, 3'd0, 1'b0);

        // 3: offer held stable while ready low
        bus.evt_ready = 1'b0; bus.sig = 8'h2B;
        tick(2); check_evt("t3_offer", 1'b1, 3'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1); check_evt("t3_hold", 1'b1, 3'd1, 1'b1);
        end
        bus.evt_ready = 1'b1;
        tick(1); check_evt("t3_done", 1'b0, 3'd0, 1'b0);

        // 4: ch4 toggles twice while blocked behind ch1 -> overflow, latest direction
        bus.evt_ready = 1'b0; bus.sig = 8'h29;
        tick(2); check_evt("t4_ch1", 1'b1, 3'd1, 1'b0);
        bus.sig = 8'h39;
        tick(1); check("t4_ovf_none", 32'(bus.overflow), 32'h00);
        bus.sig = 8'h29;
        tick(1); check("t4_ovf_set", 32'(bus.overflow), 32'h10);
        check_evt("t4_still1", 1'b1, 3'd1, 1'b0);
        bus.evt_ready = 1'b1;
        tick(1); check_evt("t4_ch4", 1'b1, 3'd4, 1'b0);
        tick(1); check_evt("t4_done", 1'b0, 3'd0, 1'b0);
        check("t4_ovf_sticky", 32'(bus.overflow), 32'h10);
        bus.overflow_clr = 8'h10;
        tick(1); bus.overflow_clr = '0;
        check("t4_ovf_clr", 32'(bus.overflow), 32'h00);

        // 5: grant ch7, then ch0 and ch7 pending -> pointer wraps, ch0 first
        bus.evt_ready = 1'b0; bus.sig = 8'hA9;
        tick(2); check_evt("t5_ch7", 1'b1, 3'd7, 1'b1);
        bus.sig = 8'h28;
        tick(1); check_evt("t5_hold7", 1'b1, 3'd7, 1'b1);
        check("t5_no_ovf", 32'(bus.overflow), 32'h00);
        bus.evt_ready = 1'b1;
        tick(1); check_evt("t5_ch0",  1'b1, 3'd0, 1'b0);
        tick(1); check_evt("t5_ch7b", 1'b1, 3'd7, 1'b0);
        tick(1); check_evt("t5_done", 1'b0, 3'd0, 1'b0);

        // 6: asynchronous reset while offering with three pending and an overflow
        bus.evt_ready = 1'b0; bus.sig = 8'h66;
        tick(2); check_evt("t6_ch1", 1'b1, 3'd1, 1'b1);
        bus.sig = 8'h6E;
        tick(1); check("t6_ovf3", 32'(bus.overflow), 32'h08);
        #3; rst = 1'b1; bus.sig = '0;
        #1;
        check("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
        check("t6_rst_ovf",   32'(bus.overflow),  32'h00);
        tick(2);
        rst = 1'b0; bus.evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1); check_evt("t6_quiet", 1'b0, 3'd0, 1'b0);
        end
        bus.sig = 8'h40;
        tick(1); check_evt("t6_lat1", 1'b0, 3'd0, 1'b0);
        tick(1); check_evt("t6_ch6",  1'b1, 3'd6, 1'b1);
        tick(1); check_evt("t6_done", 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
